// File: rtl/byte_lane_memory.sv
// Word-organised 4-lane memory with a pipelined RISC-V sized data port, a registered fetch port and a clear sweep after reset.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses are suppressed and flagged instead of being forced to alignment.
module byte_lane_memory #(
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  output logic        MEM_init_done,
  input  logic        MEM_req,
  input  logic        MEM_write_enable,
  input  logic [2:0]  MEM_size,
  input  logic [31:0] MEM_address,
  input  logic [31:0] MEM_write_data,
  output logic        MEM_ready,
  output logic        MEM_read_valid,
  output logic [31:0] MEM_read_data,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        MEM_misaligned,
`endif
  input  logic [31:0] instruction_address,
  output logic [31:0] instruction
);

  localparam int WORD_AW = ADDR_WIDTH - 2;
  localparam int DEPTH   = 1 << WORD_AW;

  typedef enum logic {CLEAR, READY} state_t;

  state_t               state;
  state_t               state_next;
  logic [WORD_AW-1:0]   clr_cnt;
  logic [31:0]          mem [DEPTH];

  logic                 accept;
  logic                 is_byte;
  logic                 is_half;
  logic                 access_fault;
  logic [1:0]           offset;
  logic [3:0]           byte_en;
  logic [31:0]          wr_word;
  logic [31:0]          rd_word;
  logic [31:0]          lane;
  logic [31:0]          ld_data;
  logic [WORD_AW-1:0]   word_idx;
  logic [WORD_AW-1:0]   fetch_idx;

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_flt;
  logic [31:0]             pipe_dat [READ_LATENCY];

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_cnt == '1) state_next = READY;
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  assign MEM_ready     = (state == READY);
  assign MEM_init_done = (state == READY);
  assign accept        = MEM_req & MEM_ready;

  assign is_byte   = (MEM_size[1:0] == 2'b00);
  assign is_half   = (MEM_size[1:0] == 2'b01);
  assign word_idx  = MEM_address[ADDR_WIDTH-1:2];
  assign fetch_idx = instruction_address[ADDR_WIDTH-1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign access_fault = (is_half & MEM_address[0]) |
                        (~is_byte & ~is_half & (MEM_address[1:0] != 2'b00));
`else
  assign access_fault = 1'b0;
`endif

  // Sub-word accesses are aligned down to their natural boundary; codes 011/110/111 behave as W.
  always_comb begin
    offset  = 2'b00;
    byte_en = 4'b1111;
    wr_word = MEM_write_data;
    if (is_byte) begin
      offset  = MEM_address[1:0];
      byte_en = 4'b0001 << MEM_address[1:0];
      wr_word = {4{MEM_write_data[7:0]}};
    end else if (is_half) begin
      offset  = {MEM_address[1], 1'b0};
      byte_en = MEM_address[1] ? 4'b1100 : 4'b0011;
      wr_word = {2{MEM_write_data[15:0]}};
    end
    if (access_fault) byte_en = 4'b0000;
  end

  always_ff @(posedge SYS_clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (accept && MEM_write_enable) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  assign rd_word = mem[word_idx];
  assign lane    = rd_word >> {offset, 3'b000};

  always_comb begin
    ld_data = rd_word;
    if (is_byte) begin
      ld_data = MEM_size[2] ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
    end else if (is_half) begin
      ld_data = MEM_size[2] ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
    end
    if (access_fault) ld_data = '0;
  end

  // Data stages only move with a valid load so the output holds its last result between pulses.
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      pipe_vld <= '0;
      pipe_flt <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_dat[i] <= '0;
    end else begin
      pipe_vld[0] <= accept & ~MEM_write_enable;
      pipe_flt[0] <= accept & access_fault;
      if (accept && !MEM_write_enable) pipe_dat[0] <= ld_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_flt[i] <= pipe_flt[i-1];
        if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign MEM_read_valid = pipe_vld[READ_LATENCY-1];
  assign MEM_read_data  = pipe_dat[READ_LATENCY-1];

`ifdef MEM_MISALIGN_TRAP_EN
  assign MEM_misaligned = pipe_flt[READ_LATENCY-1];
`else
  logic unused_flt;
  assign unused_flt = ^pipe_flt;
`endif

  // Nonblocking read gives the pre-store word when a store hits the fetched word on the same edge.
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      instruction <= '0;
    end else if (state == READY) begin
      instruction <= mem[fetch_idx];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{MEM_address[31:ADDR_WIDTH], instruction_address[31:ADDR_WIDTH],
                         instruction_address[1:0]};

endmodule
